// File: rtl/arbiter_stream_mux_if.sv
// Bundle of upstream (s_*) and downstream (m_*) stream signals around the mux.
// The master view belongs to the mux; the slave view belongs to the sources/sink.
interface arbiter_stream_mux_if #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32
);
   logic [NUM_PORTS*DATA_WIDTH-1:0] s_data;
   logic [NUM_PORTS-1:0]            s_valid;
   logic [NUM_PORTS-1:0]            s_last;
   logic [NUM_PORTS-1:0]            s_ready;
   logic [DATA_WIDTH-1:0]           m_data;
   logic                            m_valid;
   logic                            m_last;
   logic                            m_ready;

   modport master (
      input  s_data, s_valid, s_last, m_ready,
      output s_ready, m_data, m_valid, m_last
   );

   modport slave (
      output s_data, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_valid, m_last
   );
endinterface

// File: rtl/arbiter_stream_mux.sv
// Packet-aware round-robin stream mux: one upstream port owns the downstream
// stream for a whole packet, or until MAX_BEATS beats have been accepted.
module arbiter_stream_mux #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_BEATS  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   arbiter_stream_mux_if.master bus,
   output logic [NUM_PORTS-1:0] grant,
   output logic                 active
);
   localparam int PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int BEATS_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
   localparam logic [BEATS_W-1:0] BEATS_LAST = (MAX_BEATS > 0) ? BEATS_W'(MAX_BEATS - 1) : '0;
   localparam bit HAS_LIMIT = (MAX_BEATS != 0);

   typedef enum logic {IDLE, XFER} state_t;

   state_t               state_reg, state_next;
   logic [NUM_PORTS-1:0] grant_reg, grant_next;
   logic [PTR_W-1:0]     last_port_reg, last_port_next;
   logic [BEATS_W-1:0]   beats_reg, beats_next;

   logic [PTR_W-1:0]      sel_port;
   logic                  sel_found;
   logic [PTR_W-1:0]      cur_port;
   logic [DATA_WIDTH-1:0] masked_data [NUM_PORTS];
   logic [DATA_WIDTH-1:0] m_data_mux;
   logic                  m_valid_w;
   logic                  m_last_w;
   logic                  accept;
   logic                  release_now;

   // grant_reg is one-hot or zero, so an AND-OR mux is enough and yields 0 in IDLE
   genvar gi;
   generate
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_mask
         assign masked_data[gi] = grant_reg[gi] ? bus.s_data[gi*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
   endgenerate

   always_comb begin
      m_data_mux = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         m_data_mux = m_data_mux | masked_data[i];
      end
   end

   always_comb begin
      cur_port = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant_reg[i]) cur_port = PTR_W'(i);
      end
   end

   // Walk from farthest to nearest so the nearest requester after last_port wins
   always_comb begin
      logic [PTR_W-1:0] idx;
      sel_found = 1'b0;
      sel_port  = '0;
      idx       = '0;
      for (int k = NUM_PORTS; k >= 1; k--) begin
         idx = PTR_W'((int'(last_port_reg) + k) % NUM_PORTS);
         if (bus.s_valid[idx]) begin
            sel_found = 1'b1;
            sel_port  = idx;
         end
      end
   end

   assign m_valid_w   = |(bus.s_valid & grant_reg);
   assign m_last_w    = |(bus.s_last & grant_reg);
   assign accept      = m_valid_w & bus.m_ready;
   assign release_now = accept & (m_last_w | (HAS_LIMIT && (beats_reg == BEATS_LAST)));

   assign bus.m_data  = m_data_mux;
   assign bus.m_valid = m_valid_w;
   assign bus.m_last  = m_last_w;
   assign bus.s_ready = grant_reg & {NUM_PORTS{bus.m_ready}};
   assign grant       = grant_reg;
   assign active      = (state_reg == XFER);

   always_comb begin
      state_next     = state_reg;
      grant_next     = grant_reg;
      last_port_next = last_port_reg;
      beats_next     = beats_reg;
      case (state_reg)
         IDLE: begin
            if (sel_found) begin
               grant_next = NUM_PORTS'(1) << sel_port;
               beats_next = '0;
               state_next = XFER;
            end
         end
         XFER: begin
            if (accept) beats_next = beats_reg + 1'b1;
            if (release_now) begin
               state_next     = IDLE;
               grant_next     = '0;
               last_port_next = cur_port;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         grant_reg     <= '0;
         last_port_reg <= PTR_W'(NUM_PORTS - 1);
         beats_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         grant_reg     <= grant_next;
         last_port_reg <= last_port_next;
         beats_reg     <= beats_next;
      end
   end
endmodule

// File: tb/tb_arbiter_stream_mux.sv
// Randomized bench for arbiter_stream_mux: packet sources, random sink stalls,
// occasional resets, and a packet-level ownership model of who owns the stream.
module tb_arbiter_stream_mux;
   localparam int N  = 4;
   localparam int W  = 8;
   localparam int MB = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] grant;
   logic         active;

   arbiter_stream_mux_if #(.NUM_PORTS(N), .DATA_WIDTH(W)) bus ();

   arbiter_stream_mux #(.NUM_PORTS(N), .DATA_WIDTH(W), .MAX_BEATS(MB)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus    (bus),
      .grant  (grant),
      .active (active)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Source side: each port presents one beat at a time and holds it until taken
   bit         src_valid [N];
   bit         src_last  [N];
   logic [W-1:0] src_data [N];
   int         remain    [N];

   // Model: which port owns the stream (-1 = nobody), who was served last,
   // and how many beats the current owner has had accepted
   int owner = -1;
   int rr    = N - 1;
   int taken = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_sources(input int vpct);
      for (int i = 0; i < N; i++) begin
         if (!src_valid[i] && ($urandom_range(0, 99) < vpct)) begin
            if (remain[i] == 0) remain[i] = $urandom_range(1, 10);
            src_valid[i] = 1'b1;
            src_data[i]  = W'($urandom);
            src_last[i]  = (remain[i] == 1);
         end
         bus.s_valid[i]           = src_valid[i];
         bus.s_last[i]            = src_last[i];
         bus.s_data[i*W +: W]     = src_data[i];
      end
   endtask

   // One clock cycle: drive, compare combinational outputs, advance model and sources
   task automatic run_cycles(input int n, input int vpct, input int rpct,
                             input int rst_pm, input bit force_rst);
      logic [N-1:0] exp_grant;
      logic [W-1:0] exp_data;
      bit           exp_valid, exp_last, acc;
      for (int c = 0; c < n; c++) begin
         drive_sources(vpct);
         rst         = force_rst || ($urandom_range(0, 999) < rst_pm);
         bus.m_ready = ($urandom_range(0, 99) < rpct);
         #2;
         exp_grant = (owner >= 0) ? N'(1 << owner) : '0;
         exp_valid = (owner >= 0) && src_valid[owner];
         exp_last  = (owner >= 0) && src_last[owner];
         exp_data  = (owner >= 0) ? src_data[owner] : '0;
         check("grant",   32'(grant),       32'(exp_grant));
         check("active",  32'(active),      32'(owner >= 0));
         check("m_valid", 32'(bus.m_valid), 32'(exp_valid));
         check("m_last",  32'(bus.m_last),  32'(exp_last));
         check("m_data",  32'(bus.m_data),  32'(exp_data));
         check("s_ready", 32'(bus.s_ready), 32'(bus.m_ready ? exp_grant : '0));

         acc = exp_valid && bus.m_ready;
         if (rst) begin
            owner = -1;
            rr    = N - 1;
            taken = 0;
         end else if (owner < 0) begin
            for (int k = 1; k <= N && owner < 0; k++) begin
               if (src_valid[(rr + k) % N]) begin
                  owner = (rr + k) % N;
                  taken = 0;
               end
            end
         end else if (acc) begin
            taken++;
            if (exp_last || taken == MB) begin
               rr    = owner;
               owner = -1;
            end
         end

         for (int i = 0; i < N; i++) begin
            if (src_valid[i] && exp_grant[i] && bus.m_ready) begin
               $display("beat port=%0d data=%02h last=%0b rst=%0b", i, src_data[i], src_last[i], rst);
               src_valid[i] = 1'b0;
               remain[i]--;
            end
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         src_valid[i] = 1'b0;
         src_last[i]  = 1'b0;
         src_data[i]  = '0;
         remain[i]    = 0;
      end
      bus.s_valid = '0;
      bus.s_last  = '0;
      bus.s_data  = '0;
      bus.m_ready = 1'b1;
      rst         = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Reset held with every source requesting: nothing may be granted
      run_cycles(5, 100, 100, 0, 1'b1);
      run_cycles(1, 100, 100, 0, 1'b0);
      check("first_grant", 32'(grant), 32'h1);

      // Saturated traffic: strict rotation with a bubble between grants
      run_cycles(200, 100, 100, 0, 1'b0);
      // Sparse sources and heavy backpressure
      run_cycles(1000, 60, 50, 0, 1'b0);
      // Bursty sink with occasional resets landing mid-packet
      run_cycles(1000, 30, 90, 8, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
